descrambler_sync_chk: RTL and testbench

//  Parametrised self-synchronous descrambler, polynomial 1+x^TAP+x^LEN (default 1+x^39+x^58), for TDS/pad

---
 rtl/descr_pkg.sv | 18 +
 rtl/descr_lock_mon.sv | 103 ++++++++++
 rtl/descrambler_sync_chk.sv | 85 ++++++++
 tb/tb_descrambler_sync_chk.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/descr_pkg.sv
// Shared types and constants for the self-synchronous descrambler and its lock monitor.
package descr_pkg;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } descr_state_t;

  localparam int POLY_LEN = 58;
  localparam int POLY_TAP = 39;

  // Whole words needed before the history holds len received bits.
  function automatic int seed_words(input int len, input int dw);
    return (len + dw - 1) / dw;
  endfunction

endpackage

// File: rtl/descr_lock_mon.sv
// Lock monitor: SEED/HUNT/LOCKED state machine, consecutive match/mismatch run counter
// and saturating error counter. Advances only on word_valid, except chk_en and clr_err.
module descr_lock_mon
  import descr_pkg::*;
#(
  parameter int LOCK_GOOD = 8,
  parameter int LOCK_BAD  = 4,
  parameter int ERR_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             word_valid,
  input  logic             match,
  input  logic             chk_en,
  input  logic             clr_err,
  input  logic             seeded,
  output logic             locked,
  output logic             lock_loss,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int RUN_MAX = (LOCK_GOOD > LOCK_BAD) ? LOCK_GOOD : LOCK_BAD;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);

  localparam logic [RUN_W-1:0] GOOD_LAST = RUN_W'(LOCK_GOOD - 1);
  localparam logic [RUN_W-1:0] BAD_LAST  = RUN_W'(LOCK_BAD - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  descr_state_t     state, state_nxt;
  logic [RUN_W-1:0] run_cnt, run_cnt_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic             loss_nxt;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can leave one unassigned and infer a latch.
    state_nxt   = state;
    run_cnt_nxt = run_cnt;
    err_nxt     = err_cnt;
    loss_nxt    = 1'b0;

    if (!chk_en) begin
      if (state != SEED) begin
        state_nxt   = HUNT;
        run_cnt_nxt = '0;
      end
    end else if (word_valid) begin
      case (state)
        // The first word seen after seeding is already judged as a HUNT word.
        SEED, HUNT: begin
          if (state == HUNT || seeded) begin
            state_nxt = HUNT;
            if (!match) begin
              run_cnt_nxt = '0;
            end else if (run_cnt == GOOD_LAST) begin
              state_nxt   = LOCKED;
              run_cnt_nxt = '0;
            end else begin
              run_cnt_nxt = run_cnt + 1'b1;
            end
          end
        end
        LOCKED: begin
          if (match) begin
            run_cnt_nxt = '0;
          end else begin
            if (err_cnt != ERR_MAX) err_nxt = err_cnt + 1'b1;
            if (run_cnt == BAD_LAST) begin
              state_nxt   = HUNT;
              run_cnt_nxt = '0;
            end else begin
              run_cnt_nxt = run_cnt + 1'b1;
            end
          end
        end
        default: begin
          state_nxt   = SEED;
          run_cnt_nxt = '0;
        end
      endcase
    end

    if (state == LOCKED && state_nxt == HUNT) loss_nxt = 1'b1;
    // A clear beats an error counted in the same cycle.
    if (clr_err) err_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEED;
      run_cnt   <= '0;
      err_cnt   <= '0;
      lock_loss <= 1'b0;
    end else begin
      state     <= state_nxt;
      run_cnt   <= run_cnt_nxt;
      err_cnt   <= err_nxt;
      lock_loss <= loss_nxt;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: rtl/descrambler_sync_chk.sv
// Self-synchronous descrambler for 1+x^TAP+x^LEN with seeding tracker and lock monitor.
// One word per din_valid beat, din[0] earliest on the line; dout is registered one cycle after din.
module descrambler_sync_chk
  import descr_pkg::*;
#(
  parameter int DW        = 29,
  parameter int LEN       = POLY_LEN,
  parameter int TAP       = POLY_TAP,
  parameter int LOCK_GOOD = 8,
  parameter int LOCK_BAD  = 4,
  parameter int ERR_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    din,
  input  logic             din_valid,
  input  logic             bypass,
  input  logic             chk_en,
  input  logic [DW-1:0]    exp_word,
  input  logic             clr_err,
  output logic [DW-1:0]    dout,
  output logic             dout_valid,
  output logic             seeded,
  output logic             locked,
  output logic             lock_loss,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int SEED_WORDS = seed_words(LEN, DW);
  localparam int SEED_CW    = $clog2(SEED_WORDS + 1);

  // hist[0] is the oldest kept bit, hist[LEN-1] the newest; win appends the current word on top.
  logic [LEN-1:0]    hist;
  logic [LEN+DW-1:0] win;
  logic [DW-1:0]     descr;
  logic              match;
  logic [SEED_CW-1:0] seed_cnt;

  assign win = {din, hist};

  // win[LEN+i] is bit n, win[LEN+i-TAP] is bit n-TAP and win[i] is bit n-LEN.
  for (genvar i = 0; i < DW; i++) begin : g_xor
    assign descr[i] = win[LEN+i] ^ win[LEN+i-TAP] ^ win[i];
  end

  assign match = (descr == exp_word);

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the history is a flop chain, not a memory, so it is reset: pre-seed words descramble against zeros.
      hist       <= '0;
      seed_cnt   <= '0;
      seeded     <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples values from before the edge.
      dout_valid <= din_valid;
      if (din_valid) begin
        hist <= win[LEN+DW-1 -: LEN];
        dout <= bypass ? din : descr;
        if (seed_cnt != SEED_CW'(SEED_WORDS)) seed_cnt <= seed_cnt + 1'b1;
        if (seed_cnt == SEED_CW'(SEED_WORDS - 1)) seeded <= 1'b1;
      end
    end
  end

  descr_lock_mon #(
    .LOCK_GOOD (LOCK_GOOD),
    .LOCK_BAD  (LOCK_BAD),
    .ERR_W     (ERR_W)
  ) u_lock_mon (
    .clk        (clk),
    .rst        (rst),
    .word_valid (din_valid),
    .match      (match),
    .chk_en     (chk_en),
    .clr_err    (clr_err),
    .seeded     (seeded),
    .locked     (locked),
    .lock_loss  (lock_loss),
    .err_cnt    (err_cnt)
  );

endmodule

// File: tb/tb_descrambler_sync_chk.sv
// Bench for descrambler_sync_chk: serial scrambler feeds the DUT, a serial descrambler model fills a
// dout scoreboard; a phase table plus hand sequences check seeding, lock, errors, bypass and reset.
module tb_descrambler_sync_chk;

  localparam int DW    = 29;
  localparam int LEN   = 58;
  localparam int TAP   = 39;
  localparam int ERR_W = 16;
  localparam int SAT_W = 4;

  logic             clk = 1'b0;
  logic             rst, din_valid, bypass, chk_en, clr_err;
  logic [DW-1:0]    din, exp_word;
  logic [DW-1:0]    dout, dout_s;
  logic             dout_valid, seeded, locked, lock_loss;
  logic             dout_valid_s, seeded_s, locked_s, lock_loss_s;
  logic [ERR_W-1:0] err_cnt;
  logic [SAT_W-1:0] err_cnt_s;

  always #5 clk = ~clk;

  descrambler_sync_chk dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .bypass(bypass),
    .chk_en(chk_en), .exp_word(exp_word), .clr_err(clr_err),
    .dout(dout), .dout_valid(dout_valid), .seeded(seeded), .locked(locked),
    .lock_loss(lock_loss), .err_cnt(err_cnt)
  );

  // Narrow error counter copy, driven identically, to reach saturation quickly.
  descrambler_sync_chk #(.ERR_W(SAT_W)) dut_sat (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .bypass(bypass),
    .chk_en(chk_en), .exp_word(exp_word), .clr_err(clr_err),
    .dout(dout_s), .dout_valid(dout_valid_s), .seeded(seeded_s), .locked(locked_s),
    .lock_loss(lock_loss_s), .err_cnt(err_cnt_s)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int loss_seen;

  logic [LEN-1:0] scr_sr;  // scrambler state, bit 0 = most recent output bit
  logic [LEN-1:0] dsc_h;   // model descrambler history, bit 0 = most recent received bit
  logic [DW-1:0]  exp_q[$];

  typedef struct {
    string         name;
    int            words;
    int            gap;
    int            n_mask;
    logic [DW-1:0] mask;
    logic          chk;
    int            exp_locked;
    int            exp_err;
    int            exp_loss;   // -1: not compared
  } phase_t;

  phase_t ph[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic tick();
    logic [DW-1:0] e;
    @(posedge clk);
    #1;
    if (lock_loss) loss_seen++;
    if (dout_valid) begin
      if (exp_q.size() == 0) begin
        check("dout_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("dout", 64'(dout), 64'(e));
      end
    end
  endtask

  // Serial 1+x^39+x^58 scrambler with an all-zero payload.
  task automatic scramble_word(output logic [DW-1:0] w);
    logic s;
    for (int i = 0; i < DW; i++) begin
      s      = scr_sr[TAP-1] ^ scr_sr[LEN-1];
      w[i]   = s;
      scr_sr = {scr_sr[LEN-2:0], s};
    end
  endtask

  task automatic model_descr(input logic [DW-1:0] w, output logic [DW-1:0] o);
    for (int i = 0; i < DW; i++) begin
      o[i]  = w[i] ^ dsc_h[TAP-1] ^ dsc_h[LEN-1];
      dsc_h = {dsc_h[LEN-2:0], w[i]};
    end
  endtask

  task automatic send_word(input logic [DW-1:0] mask, input logic raw_en, input logic [DW-1:0] raw,
                           input logic clr, input int gap);
    logic [DW-1:0] w, o;
    scramble_word(w);
    w = raw_en ? raw : (w ^ mask);
    model_descr(w, o);
    exp_q.push_back(bypass ? w : o);
    din       = w;
    din_valid = 1'b1;
    clr_err   = clr;
    tick();
    din_valid = 1'b0;
    clr_err   = 1'b0;
    din       = DW'($urandom);
    repeat (gap) tick();
  endtask

  task automatic add_phase(input string n, input int words, input int gap, input int n_mask,
                           input logic [DW-1:0] mask, input logic chk, input int lk, input int err,
                           input int loss);
    phase_t r;
    r.name = n; r.words = words; r.gap = gap; r.n_mask = n_mask; r.mask = mask; r.chk = chk;
    r.exp_locked = lk; r.exp_err = err; r.exp_loss = loss;
    ph.push_back(r);
  endtask

  localparam logic [DW-1:0] ZERO = '0;
  localparam logic [DW-1:0] BIT0 = 29'h1;
  localparam logic [DW-1:0] BIT5 = 29'h20;

  initial begin
    scr_sr    = 58'h2A5_5AA5_A5A5_A5A5;
    dsc_h     = '0;
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    bypass    = 1'b0;
    chk_en    = 1'b1;
    exp_word  = '0;
    clr_err   = 1'b0;
    loss_seen = 0;

    //        name               words gap nmask mask chk lk  err loss
    add_phase("clean_run",        990, 0,  0,   ZERO, 1, 1,  0,  0);
    add_phase("flip_din5",          8, 0,  1,   BIT5, 1, 1,  3,  0);
    add_phase("flip_din5_gapped",   8, 2,  1,   BIT5, 1, 1,  6,  0);
    add_phase("bad_burst",         13, 0,  4,   BIT0, 1, 0, 10,  1);
    add_phase("relock",             1, 0,  0,   ZERO, 1, 1, 10,  0);
    add_phase("bad_burst_gapped",  13, 3,  4,   BIT0, 1, 0, 14,  1);
    add_phase("relock_gapped",      1, 3,  0,   ZERO, 1, 1, 14,  0);
    add_phase("chk_off",            6, 0,  1,   BIT0, 0, 0, 14, -1);
    add_phase("chk_on_hunt",        7, 0,  0,   ZERO, 1, 0, 14,  0);
    add_phase("chk_on_lock",        1, 0,  0,   ZERO, 1, 1, 14,  0);

    // Reset state
    tick();
    tick();
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_dout_valid", 64'(dout_valid), 64'd0);
    check("rst_seeded", 64'(seeded), 64'd0);
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_lock_loss", 64'(lock_loss), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    rst = 1'b0;

    // Initial seeding and lock: seeded after word 1, locked after word 9
    for (int w = 0; w < 10; w++) begin
      send_word(ZERO, 1'b0, ZERO, 1'b0, 0);
      if (w == 0) check("seed_w0", 64'(seeded), 64'd0);
      if (w == 1) check("seed_w1", 64'(seeded), 64'd1);
      if (w == 8) check("lock_w8", 64'(locked), 64'd0);
      if (w == 9) check("lock_w9", 64'(locked), 64'd1);
    end

    for (int p = 0; p < ph.size(); p++) begin
      chk_en    = ph[p].chk;
      loss_seen = 0;
      for (int k = 0; k < ph[p].words; k++)
        send_word((k < ph[p].n_mask) ? ph[p].mask : ZERO, 1'b0, ZERO, 1'b0, ph[p].gap);
      check({ph[p].name, "_locked"}, 64'(locked), 64'(ph[p].exp_locked));
      check({ph[p].name, "_err"}, 64'(err_cnt), 64'(ph[p].exp_err));
      if (ph[p].exp_loss >= 0)
        check({ph[p].name, "_loss"}, 64'(loss_seen), 64'(ph[p].exp_loss));
    end

    // Bypass: dout follows din, matching still uses the descrambled value
    bypass = 1'b1;
    repeat (3) send_word(ZERO, 1'b0, ZERO, 1'b0, 0);
    check("bypass_err", 64'(err_cnt), 64'd14);
    send_word(ZERO, 1'b1, 29'h1ABCDEF, 1'b0, 0);
    check("bypass_dout", 64'(dout), 64'h1ABCDEF);
    bypass = 1'b0;
    repeat (4) send_word(ZERO, 1'b0, ZERO, 1'b0, 0);
    check("bypass_off_locked", 64'(locked), 64'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_idle", 64'(err_cnt), 64'd0);

    // Saturation: 3 errors per 4 words keeps lock
    for (int r = 0; r < 6; r++) begin
      send_word(BIT5, 1'b0, ZERO, 1'b0, 0);
      repeat (3) send_word(ZERO, 1'b0, ZERO, 1'b0, 0);
      if (r == 4) begin
        check("sat_at_max", 64'(err_cnt_s), 64'hF);
        check("wide_at_15", 64'(err_cnt), 64'd15);
      end
    end
    check("sat_held", 64'(err_cnt_s), 64'hF);
    check("wide_18", 64'(err_cnt), 64'd18);
    check("sat_locked", 64'(locked_s), 64'd1);

    // clr_err in the same cycle as an error drops that error
    send_word(BIT5, 1'b0, ZERO, 1'b1, 0);
    check("clr_vs_err", 64'(err_cnt), 64'd0);
    check("clr_vs_err_sat", 64'(err_cnt_s), 64'd0);
    repeat (2) send_word(ZERO, 1'b0, ZERO, 1'b0, 0);
    check("err_after_clr", 64'(err_cnt), 64'd2);
    send_word(ZERO, 1'b0, ZERO, 1'b0, 0);
    check("locked_after_clr", 64'(locked), 64'd1);

    // Reset while locked, gapped valid; last word bypassed so dout is non-zero before reset
    repeat (2) send_word(ZERO, 1'b0, ZERO, 1'b0, 2);
    bypass = 1'b1;
    send_word(ZERO, 1'b0, ZERO, 1'b0, 1);
    bypass = 1'b0;
    rst = 1'b1;
    tick();
    check("mid_rst_dout", 64'(dout), 64'd0);
    check("mid_rst_dout_valid", 64'(dout_valid), 64'd0);
    check("mid_rst_seeded", 64'(seeded), 64'd0);
    check("mid_rst_locked", 64'(locked), 64'd0);
    check("mid_rst_lock_loss", 64'(lock_loss), 64'd0);
    check("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
    rst   = 1'b0;
    dsc_h = '0;
    for (int w = 0; w < 10; w++) begin
      send_word(ZERO, 1'b0, ZERO, 1'b0, 2);
      if (w == 0) check("reseed_w0", 64'(seeded), 64'd0);
      if (w == 1) check("reseed_w1", 64'(seeded), 64'd1);
      if (w == 8) check("relock_w8", 64'(locked), 64'd0);
      if (w == 9) check("relock_w9", 64'(locked), 64'd1);
    end
    check("final_err", 64'(err_cnt), 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
